// File: rtl/dm_mem_model.sv
// Parametrised data-memory model for the dm_* req/ack bus with wait states, byte lanes and range errors.
// Optional access statistics counters are enabled by defining DM_MEM_STATS_EN.
module dm_mem_model #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 65536,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk_cpu,
   input  logic                  rst_n,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_W-1:0]     dm_adr,
   input  logic [DATA_W/8-1:0]   dm_sel,
   input  logic [DATA_W-1:0]     dm_dat_i,
   output logic [DATA_W-1:0]     dm_dat_o,
   output logic                  dm_ack,
   output logic                  dm_err,
   output logic                  dm_busy,
   output logic                  dm_ovr
`ifdef DM_MEM_STATS_EN
   ,
   output logic [31:0]           st_rd,
   output logic [31:0]           st_wr,
   output logic [31:0]           st_err
`endif
);

   localparam int SEL_W = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CMP_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic                w_ack;
   logic                w_busy;

   logic                r_we;
   logic                r_ovr;
   logic                r_oor;
   logic [ADDR_W-1:0]   r_adr;
   logic [SEL_W-1:0]    r_sel;
   logic [DATA_W-1:0]   r_dat;
   logic [DATA_W-1:0]   r_dat_o;
   logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

   logic                w_accept;
   logic                w_drop;
   logic                w_in_oor;
   logic                w_rd_we;
   logic                w_rd_oor;
   logic [ADDR_W-1:0]   w_rd_adr;
   logic [IDX_W-1:0]    w_rd_idx;
   logic [IDX_W-1:0]    w_wr_idx;
   logic                w_load;
   logic                w_commit;

   assign w_accept = dm_req && (r_state == IDLE);
   assign w_drop   = dm_req && (r_state != IDLE);
   assign w_in_oor = CMP_W'(dm_adr) >= CMP_W'(DEPTH);

   // With no wait states the read data must be fetched on the accepting edge, before the latch is valid.
   assign w_rd_we  = (r_state == IDLE) ? dm_we    : r_we;
   assign w_rd_adr = (r_state == IDLE) ? dm_adr   : r_adr;
   assign w_rd_oor = (r_state == IDLE) ? w_in_oor : r_oor;
   assign w_rd_idx = w_rd_adr[IDX_W-1:0];
   assign w_wr_idx = r_adr[IDX_W-1:0];
   assign w_load   = (w_nxt == DONE) && (r_state != DONE) && !w_rd_we;
   assign w_commit = (r_state == DONE) && r_we && !r_oor;

   always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_ovr   <= 1'b0;
         r_dat_o <= '0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_we <= dm_we;
         end
         if (w_drop) begin
            r_ovr <= 1'b1;
         end
         if (w_load) begin
            r_dat_o <= w_rd_oor ? '0 : r_mem[w_rd_idx];
         end
      end
   end

   always_comb begin
      w_nxt     = r_state;
      w_cnt_nxt = r_cnt;
      w_ack     = 1'b0;
      w_busy    = 1'b0;
      case (r_state)
         IDLE: begin
            if (dm_req) begin
               w_cnt_nxt = 4'(WAIT_CYCLES);
               w_nxt     = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            w_busy = 1'b1;
            if (r_cnt <= 4'd1) begin
               w_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         DONE: begin
            w_busy = 1'b1;
            w_ack  = 1'b1;
            w_nxt  = IDLE;
         end
         default: begin
            w_nxt = IDLE;
         end
      endcase
   end

   // Request payload is plain data: captured on acceptance, never reset.
   always_ff @(posedge clk_cpu) begin
      if (w_accept) begin
         r_adr <= dm_adr;
         r_sel <= dm_sel;
         r_dat <= dm_dat_i;
         r_oor <= w_in_oor;
      end
   end

   always_ff @(posedge clk_cpu) begin
      if (w_commit) begin
         for (int i = 0; i < SEL_W; i++) begin
            if (r_sel[i]) begin
               r_mem[w_wr_idx][8*i +: 8] <= r_dat[8*i +: 8];
            end
         end
      end
   end

   assign dm_dat_o = r_dat_o;
   assign dm_ack   = w_ack;
   assign dm_err   = w_ack && r_oor;
   assign dm_busy  = w_busy;
   assign dm_ovr   = r_ovr;

`ifdef DM_MEM_STATS_EN
   logic [31:0] r_st_rd;
   logic [31:0] r_st_wr;
   logic [31:0] r_st_err;

   // Saturating event counters, all updated on the ack cycle.
   always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
         r_st_rd  <= '0;
         r_st_wr  <= '0;
         r_st_err <= '0;
      end else if (w_ack) begin
         if (r_we) begin
            if (r_st_wr != '1) begin
               r_st_wr <= r_st_wr + 32'd1;
            end
         end else begin
            if (r_st_rd != '1) begin
               r_st_rd <= r_st_rd + 32'd1;
            end
         end
         if (r_oor && (r_st_err != '1)) begin
            r_st_err <= r_st_err + 32'd1;
         end
      end
   end

   assign st_rd  = r_st_rd;
   assign st_wr  = r_st_wr;
   assign st_err = r_st_err;
`endif

endmodule

// File: tb/tb_dm_mem_model.sv
// Scoreboard bench for dm_mem_model: three instances cover zero, three and two wait states.
module tb_dm_mem_model;

   localparam int NDUT = 3;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        we;
   logic [15:0] adr;
   logic [1:0]  sel;
   logic [15:0] dat_i;
   logic        req   [NDUT];
   logic [15:0] dat_o [NDUT];
   logic        ack   [NDUT];
   logic        err   [NDUT];
   logic        busy  [NDUT];
   logic        ovr   [NDUT];

   genvar g;
   generate
      for (g = 0; g < NDUT; g++) begin : g_dut
         localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
         localparam int DP = (g == 0) ? 1024 : 65536;
         dm_mem_model #(
            .DATA_W(16), .ADDR_W(16), .DEPTH(DP), .WAIT_CYCLES(WC)
         ) u_dut (
            .clk_cpu (clk),
            .rst_n   (rst_n),
            .dm_req  (req[g]),
            .dm_we   (we),
            .dm_adr  (adr),
            .dm_sel  (sel),
            .dm_dat_i(dat_i),
            .dm_dat_o(dat_o[g]),
            .dm_ack  (ack[g]),
            .dm_err  (err[g]),
            .dm_busy (busy[g]),
            .dm_ovr  (ovr[g])
         );
      end
   endgenerate

   typedef struct {
      logic [15:0] dat;
      logic        chk_dat;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [1:0]  sel;
      logic [15:0] dat;
      logic [15:0] exp_dat;
      logic        chk_dat;
      logic        exp_err;
   } stim_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   bit          o_got;
   int          o_lat;
   logic [15:0] o_dat;
   logic        o_err;

   function automatic int lat_of(int k);
      return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
   endfunction

   function automatic stim_t mk(logic w, logic [15:0] a, logic [1:0] s, logic [15:0] d,
                                logic [15:0] ed, logic cd, logic ee);
      stim_t t;
      t.we = w; t.adr = a; t.sel = s; t.dat = d;
      t.exp_dat = ed; t.chk_dat = cd; t.exp_err = ee;
      return t;
   endfunction

   // Drives a one-cycle strobe; returns #1 after the accepting edge.
   task automatic issue(int k, logic w, logic [15:0] a, logic [1:0] s, logic [15:0] d);
      @(posedge clk); #1;
      we = w; adr = a; sel = s; dat_i = d; req[k] = 1'b1;
      @(posedge clk); #1;
      req[k] = 1'b0;
   endtask

   task automatic wait_ack(int k, int budget);
      o_got = 1'b0; o_lat = 0; o_dat = '0; o_err = 1'b0;
      for (int n = 1; n <= budget && !o_got; n++) begin
         @(negedge clk);
         if (ack[k] === 1'b1) begin
            o_got = 1'b1; o_lat = n; o_dat = dat_o[k]; o_err = err[k];
         end
      end
   endtask

   task automatic push_exp(int k, stim_t t);
      exp_t e;
      e.dat = t.exp_dat; e.chk_dat = t.chk_dat; e.err = t.exp_err; e.lat = lat_of(k);
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < NDUT; k++) req[k] = 1'b0;
      we = 1'b0; adr = '0; sel = '0; dat_i = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         n_cmp++;
         if ({ack[k], err[k], busy[k], ovr[k], dat_o[k]} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: ack=%b err=%b busy=%b ovr=%b dat=%h, want all 0",
                     k, ack[k], err[k], busy[k], ovr[k], dat_o[k]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_wait0();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(1'b1, 16'h0010, 2'b11, 16'hBEEF, 16'h0000, 1'b0, 1'b0));
      t.push_back(mk(1'b0, 16'h0010, 2'b11, 16'h0000, 16'hBEEF, 1'b1, 1'b0));
      foreach (t[i]) begin
         push_exp(0, t[i]);
         issue(0, t[i].we, t[i].adr, t[i].sel, t[i].dat);
         wait_ack(0, 20);
         e = sb.pop_front();
         n_cmp++;
         if (!o_got) begin
            n_bad++; $display("FAIL wait0_ack[%0d]: no ack within budget, want lat %0d", i, e.lat);
         end else begin
            if (o_lat != e.lat) begin n_bad++; $display("FAIL wait0_lat[%0d]: got %0d want %0d", i, o_lat, e.lat); end
            n_cmp++;
            if (o_err !== e.err) begin n_bad++; $display("FAIL wait0_err[%0d]: got %b want %b", i, o_err, e.err); end
            if (e.chk_dat) begin
               n_cmp++;
               if (o_dat !== e.dat) begin n_bad++; $display("FAIL wait0_dat[%0d]: got %h want %h", i, o_dat, e.dat); end
            end
         end
      end
   endtask

   task automatic test_byte_lanes();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(1'b1, 16'h0002, 2'b11, 16'h1234, 16'h0000, 1'b0, 1'b0));
      t.push_back(mk(1'b1, 16'h0002, 2'b10, 16'hAB00, 16'h0000, 1'b0, 1'b0));
      t.push_back(mk(1'b0, 16'h0002, 2'b00, 16'h0000, 16'hAB34, 1'b1, 1'b0));
      t.push_back(mk(1'b1, 16'h0002, 2'b00, 16'hFFFF, 16'h0000, 1'b0, 1'b0));
      t.push_back(mk(1'b0, 16'h0002, 2'b11, 16'h0000, 16'hAB34, 1'b1, 1'b0));
      t.push_back(mk(1'b1, 16'h0002, 2'b01, 16'h00CD, 16'h0000, 1'b0, 1'b0));
      t.push_back(mk(1'b0, 16'h0002, 2'b11, 16'h0000, 16'hABCD, 1'b1, 1'b0));
      foreach (t[i]) begin
         push_exp(0, t[i]);
         issue(0, t[i].we, t[i].adr, t[i].sel, t[i].dat);
         wait_ack(0, 20);
         e = sb.pop_front();
         n_cmp++;
         if (!o_got) begin
            n_bad++; $display("FAIL lanes_ack[%0d]: no ack within budget", i);
         end else begin
            if (o_err !== e.err) begin n_bad++; $display("FAIL lanes_err[%0d]: got %b want %b", i, o_err, e.err); end
            if (e.chk_dat) begin
               n_cmp++;
               if (o_dat !== e.dat) begin n_bad++; $display("FAIL lanes_dat[%0d]: got %h want %h", i, o_dat, e.dat); end
            end
         end
      end
   endtask

   task automatic test_range();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(1'b1, 16'h03FF, 2'b11, 16'h7777, 16'h0000, 1'b0, 1'b0));
      t.push_back(mk(1'b1, 16'h0400, 2'b11, 16'h5555, 16'h0000, 1'b0, 1'b1));
      t.push_back(mk(1'b0, 16'h0400, 2'b11, 16'h0000, 16'h0000, 1'b1, 1'b1));
      t.push_back(mk(1'b0, 16'h03FF, 2'b11, 16'h0000, 16'h7777, 1'b1, 1'b0));
      t.push_back(mk(1'b1, 16'hFFFF, 2'b11, 16'h0101, 16'h7777, 1'b1, 1'b1));
      t.push_back(mk(1'b0, 16'h0000, 2'b11, 16'h0000, 16'h0000, 1'b0, 1'b0));
      foreach (t[i]) begin
         push_exp(0, t[i]);
         issue(0, t[i].we, t[i].adr, t[i].sel, t[i].dat);
         wait_ack(0, 20);
         e = sb.pop_front();
         n_cmp++;
         if (!o_got) begin
            n_bad++; $display("FAIL range_ack[%0d]: no ack within budget", i);
         end else begin
            if (o_err !== e.err) begin n_bad++; $display("FAIL range_err[%0d]: got %b want %b", i, o_err, e.err); end
            if (e.chk_dat) begin
               n_cmp++;
               if (o_dat !== e.dat) begin n_bad++; $display("FAIL range_dat[%0d]: got %h want %h", i, o_dat, e.dat); end
            end
         end
      end
   endtask

   task automatic test_wait3();
      exp_t e;
      issue(1, 1'b1, 16'h0030, 2'b11, 16'hC3C3);
      wait_ack(1, 20);
      n_cmp++;
      if (!o_got || o_lat != 4) begin
         n_bad++; $display("FAIL wait3_wr_lat: got=%0b lat=%0d want lat 4", o_got, o_lat);
      end
      e.dat = 16'hC3C3; e.chk_dat = 1'b1; e.err = 1'b0; e.lat = 4;
      sb.push_back(e);
      @(posedge clk); #1;
      we = 1'b0; adr = 16'h0030; sel = 2'b11; req[1] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL wait3_busy_pre: got %b want 0", busy[1]); end
      @(posedge clk); #1;
      req[1] = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         n_cmp++;
         if (busy[1] !== (n <= 4)) begin n_bad++; $display("FAIL wait3_busy[%0d]: got %b want %b", n, busy[1], (n <= 4)); end
         n_cmp++;
         if (ack[1] !== (n == 4)) begin n_bad++; $display("FAIL wait3_ack[%0d]: got %b want %b", n, ack[1], (n == 4)); end
         if (ack[1] === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (dat_o[1] !== e.dat) begin n_bad++; $display("FAIL wait3_dat: got %h want %h", dat_o[1], e.dat); end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_bad++; $display("FAIL wait3_sb: %0d expected acks never seen, want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_overrun();
      int n_ack = 0;
      int ack_at = 0;
      @(posedge clk); #1;
      we = 1'b1; adr = 16'h0040; sel = 2'b11; dat_i = 16'h5A5A; req[2] = 1'b1;
      @(posedge clk); #1;
      dat_i = 16'hFFFF;
      @(posedge clk); #1;
      req[2] = 1'b0;
      for (int n = 2; n <= 10; n++) begin
         @(negedge clk);
         if (ack[2] === 1'b1) begin n_ack++; ack_at = n; end
      end
      n_cmp++;
      if (n_ack != 1 || ack_at != 3) begin
         n_bad++; $display("FAIL ovr_acks: got %0d acks (last at %0d), want 1 at 3", n_ack, ack_at);
      end
      n_cmp++;
      if (ovr[2] !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", ovr[2]); end
      issue(2, 1'b0, 16'h0040, 2'b11, 16'h0000);
      wait_ack(2, 20);
      n_cmp++;
      if (!o_got || o_dat !== 16'h5A5A) begin
         n_bad++; $display("FAIL ovr_dropped_wr: got=%0b dat=%h want 5a5a", o_got, o_dat);
      end
      n_cmp++;
      if (ovr[2] !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", ovr[2]); end
   endtask

   task automatic test_reset_mid();
      int n_ack = 0;
      issue(2, 1'b1, 16'h0020, 2'b11, 16'h1111);
      wait_ack(2, 20);
      n_cmp++;
      if (!o_got) begin n_bad++; $display("FAIL rstmid_wr1: no ack within budget"); end
      issue(2, 1'b1, 16'h0020, 2'b11, 16'h2222);
      @(negedge clk);
      n_cmp++;
      if (busy[2] !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %b want 1", busy[2]); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ack[2], err[2], busy[2], ovr[2], dat_o[2]} !== 20'h0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: ack=%b err=%b busy=%b ovr=%b dat=%h, want all 0",
                  ack[2], err[2], busy[2], ovr[2], dat_o[2]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (ack[2] === 1'b1) n_ack++;
      end
      n_cmp++;
      if (n_ack != 0) begin n_bad++; $display("FAIL rstmid_noack: got %0d acks want 0", n_ack); end
      issue(2, 1'b0, 16'h0020, 2'b11, 16'h0000);
      wait_ack(2, 20);
      n_cmp++;
      if (!o_got || o_dat !== 16'h1111) begin
         n_bad++; $display("FAIL rstmid_old_data: got=%0b dat=%h want 1111", o_got, o_dat);
      end
   endtask

   initial begin
      test_reset();
      test_wait0();
      test_byte_lanes();
      test_range();
      test_wait3();
      test_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dm_mem_model.md
Name: dm_mem_model

Overview:
- Parametrised, simulation-oriented data-memory model for the CPU data bus (dm_* req/ack handshake).
- Adds configurable width, depth, wait states, byte-lane writes and out-of-range error reporting.
- Instantiated in the Verilator top in place of the fixed one-cycle ack data-memory stub.
- Synthesisable; inferred array, no tri-states.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8.
ADDR_W, 16, word-address width.
DEPTH, 65536, number of implemented words; must be >= 1 and <= 2**ADDR_W.
WAIT_CYCLES, 0, extra cycles between request acceptance and ack; range 0..15.

Ports:
clk_cpu  in  1  sole clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
dm_req  in  1  one-cycle request strobe.
dm_we  in  1  1 = write, 0 = read; sampled with dm_req.
dm_adr  in  ADDR_W  word address; sampled with dm_req.
dm_sel  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i]; ignored on reads.
dm_dat_i  in  DATA_W  write data; sampled with dm_req.
dm_dat_o  out  DATA_W  read data; valid in the dm_ack cycle and held until the next read ack.
dm_ack  out  1  one-cycle completion pulse.
dm_err  out  1  one-cycle pulse coincident with dm_ack when the address is >= DEPTH.
dm_busy  out  1  high from acceptance until the ack cycle inclusive.
dm_ovr  out  1  sticky flag: a request strobe was dropped while busy.

Behaviour:
- Reset (asynchronous, active-low):
  - State returns to IDLE and the wait counter clears.
  - dm_dat_o, dm_ack, dm_err, dm_busy and dm_ovr reset to 0.
  - Memory contents are not reset.
  - A pending write caught by reset mid-operation is discarded.
- States: IDLE, WAIT, DONE.
- IDLE:
  - dm_req=1 latches dm_we, dm_adr, dm_sel and dm_dat_i, loads the counter with WAIT_CYCLES and raises busy.
  - Goes to DONE if WAIT_CYCLES=0, else to WAIT.
- WAIT: counter decrements each cycle; goes to DONE when it reaches 1.
- DONE:
  - dm_ack=1 for this single cycle, then back to IDLE.
  - Writes commit to the array in this cycle, selected lanes only.
  - Reads load dm_dat_o from the latched address in this cycle.
- Latency: strobe in cycle N gives ack in cycle N+1+WAIT_CYCLES. WAIT_CYCLES=0 is equivalent to a one-cycle ack.
- Back-to-back: a strobe is accepted only in IDLE. The earliest next strobe is the cycle after ack.
- A strobe in WAIT or DONE is dropped (no ack is ever produced for it) and sets dm_ovr. dm_ovr clears only on reset.
- Out-of-range (latched address >= DEPTH):
  - ack is still produced, with dm_err=1 in the same cycle.
  - A write is dropped.
  - A read returns all zeros on dm_dat_o.
- Array index uses the address modulo nothing: no wrap; out-of-range is always an error.
- dm_sel=0 on a write completes normally with ack and leaves memory unchanged.
- Read-after-write to the same address: the later read observes the committed write.

Optional Feature:
DM_MEM_STATS_EN:
- Defined: adds outputs st_rd (32), st_wr (32) and st_err (32).
  - These count acked reads, acked writes and dm_err pulses.
  - All three reset to 0 and saturate at 2**32-1.
  - Each increments in the ack cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=0: write 16'hBEEF to 0x0010 with sel=2'b11, then read 0x0010 -> each ack one cycle after its req; dm_dat_o=16'hBEEF in the read ack cycle.
- WAIT_CYCLES=3: read strobe at cycle 10 -> dm_busy high cycles 11-14; dm_ack only at cycle 14.
- Byte lanes: write 16'h1234 sel=11, then 16'hAB00 sel=10 to 0x0002; read 0x0002 -> 16'hAB34.
- DEPTH=1024: write 16'h5555 to 0x0400 -> ack with dm_err=1; read 0x0400 -> 16'h0000 with dm_err=1; read 0x03FF is unaffected.
- WAIT_CYCLES=2: second strobe one cycle after the first -> only one ack; dm_ovr=1 and stays 1 until rst_n is low.
- Write strobe, then rst_n low during WAIT -> all outputs 0 immediately; no ack; a later read of that address returns the old contents.
